musa_fetch_stage: RTL and testbench
===================================

// Module: musa_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MUSA core. Owns the 18-bit program counter.
//  Issues word fetches to instruction memory over a req/ack handshake and buffers returned words in a 2-entry queue toward decode.
//  Exports pc_plus1 as the sequential input of the 18-bit next-PC select mux. Loads that mux's output (next_pc) on redirect.
// PARAMETERS
//  ADDR_W    18      PC / instruction-memory word-address width
//  INSTR_W   32      instruction word width
//  RESET_PC  18'h0   PC value after reset
// PORTS
//  clk         in   1        single core clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  next_pc     in   ADDR_W   redirect target from next-PC select mux
//  pc_load     in   1        1-cycle pulse: redirect to next_pc, squash younger fetches
//  pc_plus1    out  ADDR_W   pc + 1 (combinational), to next-PC mux
//  imem_req    out  1        fetch request (registered)
//  imem_addr   out  ADDR_W   fetch word address (registered, equals pc)
//  imem_ack    in   1        transfer completes in any cycle with imem_req && imem_ack
//  imem_rdata  in   INSTR_W  instruction word, valid with imem_ack
//  id_valid    out  1        head of queue valid toward decode
//  id_ready    in   1        decode accepts head (pop when id_valid && id_ready)
//  id_instr    out  INSTR_W  head instruction
//  id_pc       out  ADDR_W   address of head instruction
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, imem_req=0, queue empty, id_valid=0.
//   Reset also sets id_instr=0, id_pc=0, state=IDLE and redirect_pc=0.
//  pc_plus1 = pc + 1 mod 2^ADDR_W (18'h3FFFF -> 18'h00000). No other arithmetic.
//  Handshake: while imem_req=1, imem_addr is held stable until the ack cycle. At most one request is outstanding.
//   Reset mid-transaction abandons the request; memory must tolerate this.
//  FSM states: IDLE (no request), WAIT (request live, keep data), DROP (request live, discard data).
//  IDLE:
//   - pc_load: pc<=next_pc, queue cleared.
//   - Else if queue count <= 1: imem_req<=1, go to WAIT.
//  WAIT, ack without pc_load:
//   - Push {pc, imem_rdata}; pc<=pc_plus1.
//   - Stay in WAIT (imem_req held) if post-push/pop count <= 1. Otherwise imem_req<=0 and go to IDLE.
//  WAIT, pc_load without ack: queue cleared, redirect_pc<=next_pc, go to DROP. imem_addr unchanged.
//  WAIT, pc_load with ack: data discarded, queue cleared, pc<=next_pc, stay in WAIT (new request next cycle).
//  DROP:
//   - Further pc_load overwrites redirect_pc (latest wins).
//   - On ack: data discarded, pc<=redirect_pc, or next_pc if pc_load in the same cycle. Stay in WAIT.
//  Queue:
//   - Registered outputs: a word acked in cycle N is visible on id_* in cycle N+1.
//   - Simultaneous push and pop are allowed at any count.
//   - Queue is never full at ack, because requests are only issued with count <= 1.
//   - pc_load clears the queue in the same edge and overrides a coincident pop.
//   - id_instr/id_pc hold their value while id_valid && !id_ready.
//  Throughput: 1 instr/cycle with zero-wait memory (ack in the request cycle) and id_ready=1.
//   First id_valid appears 2 cycles after reset release.
// STRUCTURE
//  Shared package musa_pkg holds:
//   - ADDR_W and INSTR_W constants.
//   - fetch FSM state encoding (IDLE/WAIT/DROP).
//   - fetch queue entry typedef {pc, instr}.
//  Sub-module musa_fetch_q2: 2-entry FIFO with push, pop, clear, count, and registered head outputs.
//  Top level contains the PC register, redirect_pc register, FSM and request logic.
// TESTING
//  1 Reset release, imem_ack=1 always, id_ready=1:
//     imem_addr 0,1,2,3 on consecutive cycles; id_pc 0,1,2 one per cycle.
//     First id_valid exactly 2 cycles after release.
//  2 id_ready=0 from start:
//     after 2 acks imem_req=0 and id_pc stays 0.
//     Raise id_ready: id_pc 0,1,2,... with no gap, loss or duplicate.
//  3 imem_ack delayed 3 cycles; pulse pc_load with next_pc=18'h00100 in the 1st wait cycle:
//     imem_addr held at the old value until ack, returned word never appears on id_*.
//     Next imem_addr=18'h00100.
//  4 pc_load (next_pc=18'h00040) in the same cycle as ack:
//     acked word dropped, queue empty next cycle, next imem_addr=18'h00040.
//  5 RESET_PC=18'h3FFFF: pc_plus1=18'h00000; second fetch address 18'h00000, id_pc 3FFFF then 00000.
//  6 Assert rst mid-WAIT between clock edges:
//     imem_req, id_valid drop and pc=RESET_PC before the next edge.
//     Fetch resumes normally after release.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared definitions for the MUSA core: datapath widths, fetch FSM states
// and the fetch-queue entry layout.
package musa_pkg;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/musa_fetch_q2.sv
// Two-entry fetch queue. The head entry lives in its own register so the
// decode-facing outputs come straight from flops.
module musa_fetch_q2
  import musa_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         valid
);

  fetch_entry_t tail;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign valid  = (count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop_ok) begin
            head <= din;
          end else if (push) begin
            tail  <= din;
            count <= 2'd2;
          end else if (pop_ok) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: a push only arrives together with a pop, so the tail shifts up.
          if (pop_ok) begin
            head <= tail;
            if (push) begin
              tail <= din;
            end else begin
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/musa_fetch_stage.sv
// MUSA instruction-fetch stage: PC register, redirect handling and the
// req/ack fetch FSM feeding a 2-entry queue toward decode.
module musa_fetch_stage #(
  parameter int unsigned       ADDR_W   = musa_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = musa_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               pc_load,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
);

  import musa_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_pc;
  fetch_state_t      state;

  logic              q_push;
  logic              q_pop;
  logic [1:0]        q_count;
  logic              keep_requesting;
  fetch_entry_t      q_din;
  fetch_entry_t      q_head;

  assign pc_plus1  = pc + ADDR_W'(1);
  assign imem_addr = pc;

  assign q_pop  = id_valid && id_ready;
  assign q_push = (state == WAIT) && imem_ack && !pc_load;
  assign q_din  = '{pc: pc, instr: imem_rdata};

  // Occupancy after this push stays <= 1 only if the queue was empty or is popping.
  assign keep_requesting = (q_count == 2'd0) || q_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      redirect_pc <= '0;
      state       <= IDLE;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= next_pc;
          end else if (q_count <= 2'd1) begin
            imem_req <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack && pc_load) begin
            pc <= next_pc;
          end else if (imem_ack) begin
            pc <= pc_plus1;
            if (!keep_requesting) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end else if (pc_load) begin
            redirect_pc <= next_pc;
            state       <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc    <= pc_load ? next_pc : redirect_pc;
            state <= WAIT;
          end else if (pc_load) begin
            redirect_pc <= next_pc;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  musa_fetch_q2 u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (pc_load),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .valid (id_valid)
  );

  assign id_instr = q_head.instr;
  assign id_pc    = q_head.pc;

endmodule

// File: tb/tb_musa_fetch_stage.sv
// Directed bench for musa_fetch_stage: streaming, backpressure, redirects,
// PC wrap and asynchronous reset.
module tb_musa_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] next_pc = '0;
  logic        pc_load = 1'b0;
  logic [17:0] pc_plus1;
  logic        imem_req;
  logic [17:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [17:0] id_pc;

  logic        rst2 = 1'b1;
  logic [17:0] pc_plus1_2, imem_addr2, id_pc2;
  logic        imem_req2, id_valid2;
  logic [31:0] imem_rdata2, id_instr2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {14'h2B5, a};
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  musa_fetch_stage dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .pc_load(pc_load), .pc_plus1(pc_plus1),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  musa_fetch_stage #(.RESET_PC(18'h3FFFF)) dut_wrap (
    .clk(clk), .rst(rst2), .next_pc(18'h0), .pc_load(1'b0), .pc_plus1(pc_plus1_2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(1'b1), .imem_rdata(imem_rdata2),
    .id_valid(id_valid2), .id_ready(1'b1), .id_instr(id_instr2), .id_pc(id_pc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, release 1 time unit after it.
  task automatic do_reset(input logic ack, input logic ready);
    rst = 1'b1; pc_load = 1'b0; next_pc = '0;
    imem_ack = ack; id_ready = ready;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %h exp 0", imem_req); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL rst_valid got %h exp 0", id_valid); else passed++;
    total++; if (imem_addr !== 18'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else passed++;
    total++; if (id_pc !== 18'h0) $display("FAIL rst_id_pc got %h exp 0", id_pc); else passed++;
    total++; if (id_instr !== 32'h0) $display("FAIL rst_id_instr got %h exp 0", id_instr); else passed++;
    total++; if (pc_plus1 !== 18'h1) $display("FAIL rst_pc_plus1 got %h exp 1", pc_plus1); else passed++;
  endtask

  task automatic test_stream();
    // Reset was released by test_reset; ack and ready held high.
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL st_req1 got %h exp 1", imem_req); else passed++;
    total++; if (imem_addr !== 18'h0) $display("FAIL st_addr0 got %h exp 0", imem_addr); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL st_valid_early got %h exp 0", id_valid); else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (imem_addr !== 18'(i)) $display("FAIL st_addr%0d got %h exp %h", i, imem_addr, 18'(i)); else passed++;
      total++; if (id_valid !== 1'b1) $display("FAIL st_valid%0d got %h exp 1", i, id_valid); else passed++;
      total++; if (id_pc !== 18'(i - 1)) $display("FAIL st_id_pc%0d got %h exp %h", i, id_pc, 18'(i - 1)); else passed++;
      total++; if (id_instr !== mem_word(18'(i - 1))) $display("FAIL st_instr%0d got %h exp %h", i, id_instr, mem_word(18'(i - 1))); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] got [6];
    int n;
    do_reset(1'b1, 1'b0);
    tick(); tick(); tick();
    total++; if (imem_req !== 1'b0) $display("FAIL bp_req_drop got %h exp 0", imem_req); else passed++;
    total++; if (id_pc !== 18'h0) $display("FAIL bp_id_pc_a got %h exp 0", id_pc); else passed++;
    tick();
    total++; if (imem_req !== 1'b0) $display("FAIL bp_req_hold got %h exp 0", imem_req); else passed++;
    total++; if (id_pc !== 18'h0 || id_valid !== 1'b1) $display("FAIL bp_id_hold got %h/%h exp 0/1", id_pc, id_valid); else passed++;
    id_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (id_valid) begin
        got[n] = id_pc;
        n++;
      end
      tick();
    end
    total++; if (n != 6) $display("FAIL bp_timeout got %0d exp 6", n); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (i < n && got[i] !== 18'(i)) $display("FAIL bp_seq%0d got %h exp %h", i, got[i], 18'(i)); else passed++;
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b0, 1'b1);
    tick();
    next_pc = 18'h00100; pc_load = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      pc_load = 1'b0;
      total++; if (imem_addr !== 18'h0 || imem_req !== 1'b1) $display("FAIL rw_hold%0d got %h/%h exp 0/1", i, imem_addr, imem_req); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL rw_valid%0d got %h exp 0", i, id_valid); else passed++;
    end
    imem_ack = 1'b1;
    tick();
    total++; if (imem_addr !== 18'h00100) $display("FAIL rw_new_addr got %h exp 00100", imem_addr); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL rw_dropped got %h exp 0", id_valid); else passed++;
    tick();
    total++; if (id_valid !== 1'b1 || id_pc !== 18'h00100) $display("FAIL rw_first got %h/%h exp 1/00100", id_valid, id_pc); else passed++;
  endtask

  task automatic test_redirect_ack();
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick();
    total++; if (imem_addr !== 18'h2 || id_pc !== 18'h1) $display("FAIL ra_pre got %h/%h exp 2/1", imem_addr, id_pc); else passed++;
    next_pc = 18'h00040; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    total++; if (id_valid !== 1'b0) $display("FAIL ra_empty got %h exp 0", id_valid); else passed++;
    total++; if (imem_addr !== 18'h00040 || imem_req !== 1'b1) $display("FAIL ra_addr got %h/%h exp 00040/1", imem_addr, imem_req); else passed++;
    tick();
    total++; if (id_valid !== 1'b1 || id_pc !== 18'h00040) $display("FAIL ra_first got %h/%h exp 1/00040", id_valid, id_pc); else passed++;
    total++; if (id_instr !== mem_word(18'h00040)) $display("FAIL ra_instr got %h exp %h", id_instr, mem_word(18'h00040)); else passed++;
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    total++; if (pc_plus1_2 !== 18'h0) $display("FAIL wr_plus1 got %h exp 00000", pc_plus1_2); else passed++;
    tick();
    total++; if (imem_addr2 !== 18'h3FFFF || imem_req2 !== 1'b1) $display("FAIL wr_addr0 got %h/%h exp 3ffff/1", imem_addr2, imem_req2); else passed++;
    tick();
    total++; if (imem_addr2 !== 18'h0) $display("FAIL wr_addr1 got %h exp 00000", imem_addr2); else passed++;
    total++; if (id_valid2 !== 1'b1 || id_pc2 !== 18'h3FFFF) $display("FAIL wr_id0 got %h/%h exp 1/3ffff", id_valid2, id_pc2); else passed++;
    tick();
    total++; if (id_pc2 !== 18'h0 || id_instr2 !== mem_word(18'h0)) $display("FAIL wr_id1 got %h/%h exp 00000/%h", id_pc2, id_instr2, mem_word(18'h0)); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick();
    total++; if (imem_req !== 1'b1 || id_valid !== 1'b1 || imem_addr !== 18'h2) $display("FAIL ar_pre got %h/%h/%h exp 1/1/2", imem_req, id_valid, imem_addr); else passed++;
    #3 rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || id_valid !== 1'b0) $display("FAIL ar_drop got %h/%h exp 0/0", imem_req, id_valid); else passed++;
    total++; if (imem_addr !== 18'h0 || pc_plus1 !== 18'h1) $display("FAIL ar_pc got %h/%h exp 0/1", imem_addr, pc_plus1); else passed++;
    #1 rst = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 18'h0) $display("FAIL ar_resume_req got %h/%h exp 1/0", imem_req, imem_addr); else passed++;
    tick();
    total++; if (id_valid !== 1'b1 || id_pc !== 18'h0) $display("FAIL ar_resume_id0 got %h/%h exp 1/0", id_valid, id_pc); else passed++;
    tick();
    total++; if (id_pc !== 18'h1) $display("FAIL ar_resume_id1 got %h exp 1", id_pc); else passed++;
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
